// File: rtl/barrel_shifter_pipe.sv
// Pipelined log barrel shifter: one registered stage per shift-amount bit, valid/ready on both sides.
// Optional rotate datapath built only when BARREL_SHIFTER_ROTATE_EN is defined (mode 10 = logical otherwise).
module barrel_shifter_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [SHW-1:0]   n,
    input  logic             izq,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    logic adv;

    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] a,
        input int               s,
        input logic             l,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        if (l)
            r = a << s;
        else if (m == 2'b01)
            r = $signed(a) >>> s;
        else
            r = a >> s;
`ifdef BARREL_SHIFTER_ROTATE_EN
        if (m == 2'b10)
            r = l ? ((a << s) | (a >> (WIDTH - s))) : ((a >> s) | (a << (WIDTH - s)));
`endif
        return r;
    endfunction

    // Every stage moves together; a stalled output freezes the whole pipe.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic [WIDTH-1:0] src_d;
        logic [SHW-1:0]   src_n;
        logic             src_izq;
        logic [1:0]       src_mode;
        logic             src_v;

        logic [WIDTH-1:0] d_q;
        logic [SHW-1:0]   n_q;
        logic             izq_q;
        logic [1:0]       mode_q;
        logic             v_q;

        if (k == 0) begin : g_first
            assign src_d    = x;
            assign src_n    = n;
            assign src_izq  = izq;
            assign src_mode = mode;
            assign src_v    = in_valid;
        end else begin : g_next
            assign src_d    = g_stage[k-1].d_q;
            assign src_n    = g_stage[k-1].n_q;
            assign src_izq  = g_stage[k-1].izq_q;
            assign src_mode = g_stage[k-1].mode_q;
            assign src_v    = g_stage[k-1].v_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q    <= '0;
                n_q    <= '0;
                izq_q  <= 1'b0;
                mode_q <= 2'b00;
                v_q    <= 1'b0;
            end else if (adv) begin
                d_q    <= src_n[k] ? shift_stage(src_d, 1 << k, src_izq, src_mode) : src_d;
                n_q    <= src_n;
                izq_q  <= src_izq;
                mode_q <= src_mode;
                v_q    <= src_v;
            end
        end
    end

    assign out_valid = g_stage[SHW-1].v_q;
    assign y         = g_stage[SHW-1].d_q;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (WIDTH=8): single beats, fill rules, n=0, stalled stream, reset flush.
module tb_barrel_shifter_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       izq = 1'b0;
    logic [7:0] x = '0;
    logic [2:0] n = '0;
    logic [1:0] mode = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] y;

    int tests = 0;
    int failed = 0;

`ifdef BARREL_SHIFTER_ROTATE_EN
    localparam logic [7:0] ROTL_EXP = 8'hB4;
    localparam logic [7:0] ROTR_EXP = 8'hD2;
`else
    localparam logic [7:0] ROTL_EXP = 8'hB0;
    localparam logic [7:0] ROTR_EXP = 8'h12;
`endif

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .n(n), .izq(izq), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] xv, input logic [2:0] nv, input logic l, input logic [1:0] m);
        in_valid = 1'b1;
        x        = xv;
        n        = nv;
        izq      = l;
        mode     = m;
    endtask

    task automatic single(input string tag, input logic [7:0] xv, input logic [2:0] nv,
                          input logic l, input logic [1:0] m, input logic [7:0] exp);
        @(negedge clk);
        out_ready = 1'b1;
        drive(xv, nv, l, m);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, {7'b0, out_valid}, 8'd0);
        @(negedge clk);
        check({tag, "_lat2"}, {7'b0, out_valid}, 8'd0);
        @(negedge clk);
        check({tag, "_valid"}, {7'b0, out_valid}, 8'd1);
        check({tag, "_y"}, y, exp);
    endtask

    logic [7:0] sx [8] = '{8'h96, 8'h96, 8'h96, 8'h81, 8'h81, 8'hF0, 8'h0F, 8'h7E};
    logic [2:0] sn [8] = '{3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd4, 3'd2, 3'd5};
    logic       sl [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] sm [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
    logic [7:0] se [8] = '{8'hB0, 8'hF2, 8'h12, 8'h02, 8'hC0, 8'h0F, 8'h3C, 8'h03};

    initial begin
        int sent;
        int got;
        logic hold;
        logic [7:0] held;

        repeat (2) @(negedge clk);
        check("rst_out_valid", {7'b0, out_valid}, 8'd0);
        check("rst_y", y, 8'h00);
        check("rst_in_ready", {7'b0, in_ready}, 8'd1);
        rst_n = 1'b1;

        single("lsl3", 8'h96, 3'd3, 1'b1, 2'b00, 8'hB0);
        single("asr3", 8'h96, 3'd3, 1'b0, 2'b01, 8'hF2);
        single("lsr3", 8'h96, 3'd3, 1'b0, 2'b00, 8'h12);
        single("rotl3", 8'h96, 3'd3, 1'b1, 2'b10, ROTL_EXP);
        single("rotr3", 8'h96, 3'd3, 1'b0, 2'b10, ROTR_EXP);
        single("asl3", 8'h96, 3'd3, 1'b1, 2'b01, 8'hB0);
        single("asr7", 8'h96, 3'd7, 1'b0, 2'b01, 8'hFF);
        single("lsl7", 8'h01, 3'd7, 1'b1, 2'b00, 8'h80);
        single("rsv_r1", 8'h96, 3'd1, 1'b0, 2'b11, 8'h4B);

        for (int l = 0; l < 2; l++)
            for (int m = 0; m < 4; m++)
                single("n0", 8'hA5, 3'd0, l[0], m[1:0], 8'hA5);

        // back-to-back stream with out_ready low in cycles 4..6
        sent = 0;
        got  = 0;
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hold) check("stall_y_stable", y, held);
            out_ready = !(c >= 4 && c <= 6);
            if (sent < 8) drive(sx[sent], sn[sent], sl[sent], sm[sent]);
            else in_valid = 1'b0;
            #1;
            if (c >= 4 && c <= 6) check("stall_in_ready", {7'b0, in_ready}, 8'd0);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (got < 8) check("stream_y", y, se[got]);
                got++;
            end
            hold = out_valid && !out_ready;
            held = y;
        end
        check("stream_count", 8'(got), 8'd8);
        out_ready = 1'b1;

        // reset with three beats in flight
        @(negedge clk);
        drive(8'h96, 3'd3, 1'b1, 2'b00);
        @(negedge clk);
        drive(8'h81, 3'd1, 1'b0, 2'b01);
        @(negedge clk);
        drive(8'hF0, 3'd4, 1'b0, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", {7'b0, out_valid}, 8'd0);
        check("midrst_y", y, 8'h00);
        check("midrst_in_ready", {7'b0, in_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_stale_beat", {7'b0, out_valid}, 8'd0);
        end
        single("post_rst", 8'h96, 3'd3, 1'b0, 2'b01, 8'hF2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
